// File: rtl/timer_sched_pkg.sv
// Shared types and timer register constants for the one-shot delay scheduler.
// The ABORT state exists only when TIMER_DELAY_SCHED_ABORT_EN is defined.
package timer_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_PL,
        ST_WR_PH,
        ST_WR_CTRL,
        ST_WAIT_IRQ,
        ST_WR_STAT,
        ST_DONE
`ifdef TIMER_DELAY_SCHED_ABORT_EN
        , ST_ABORT
`endif
    } state_t;

    localparam logic [2:0] TMR_ADDR_STATUS  = 3'd0;
    localparam logic [2:0] TMR_ADDR_CONTROL = 3'd1;
    localparam logic [2:0] TMR_ADDR_PERIODL = 3'd2;
    localparam logic [2:0] TMR_ADDR_PERIODH = 3'd3;

    localparam logic [15:0] CTRL_BIT_ITO   = 16'h0001;
    localparam logic [15:0] CTRL_BIT_CONT  = 16'h0002;
    localparam logic [15:0] CTRL_BIT_START = 16'h0004;
    localparam logic [15:0] CTRL_BIT_STOP  = 16'h0008;

    localparam logic [15:0] CTRL_ONESHOT_START = CTRL_BIT_ITO | CTRL_BIT_START;
    localparam logic [15:0] CTRL_STOP          = CTRL_BIT_STOP;
    localparam logic [15:0] STATUS_CLEAR       = 16'h0000;

    // A zero period would never time out, so the shortest delay is one cycle.
    function automatic logic [31:0] clamp_delay(input logic [31:0] d);
        return (d == 32'd0) ? 32'd1 : d;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first asserted request at or after ptr,
// wrapping around; the pointer register lives in the parent.
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int IDX_W = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_REQ-1:0] grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             any
);

    logic             found;
    logic [IDX_W-1:0] cand;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        cand      = '0;
        for (int i = 0; i < N_REQ; i++) begin
            cand = IDX_W'((int'(ptr) + i) % N_REQ);
            if (!found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/timer_delay_sched.sv
// Shares one interval timer among N_REQ one-shot delay requesters.
// Define TIMER_DELAY_SCHED_ABORT_EN to add the per-requester abort input.
module timer_delay_sched
    import timer_sched_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int IDX_W = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [N_REQ-1:0]     req,
    input  logic [32*N_REQ-1:0]  delay,
`ifdef TIMER_DELAY_SCHED_ABORT_EN
    input  logic [N_REQ-1:0]     abort,
`endif
    output logic [N_REQ-1:0]     done,
    output logic                 sched_active,
    output logic [IDX_W-1:0]     grant_id,
    output logic [2:0]           tmr_address,
    output logic                 tmr_chipselect,
    output logic                 tmr_write_n,
    output logic [15:0]          tmr_writedata,
    input  logic                 tmr_irq
);

    state_t           state;
    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] next_ptr;
    logic [N_REQ-1:0] owner_oh;
    logic [15:0]      delay_hi;

    logic [N_REQ-1:0] arb_grant;
    logic [IDX_W-1:0] arb_idx;
    logic             arb_any;
    logic [31:0]      sel_delay;
    logic [31:0]      clamped_delay;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_arb (
        .req       (req),
        .ptr       (rr_ptr),
        .grant     (arb_grant),
        .grant_idx (arb_idx),
        .any       (arb_any)
    );

    always_comb begin
        sel_delay = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (arb_idx == IDX_W'(i)) sel_delay = delay[32*i +: 32];
        end
    end

    assign clamped_delay = clamp_delay(sel_delay);
    assign next_ptr      = (grant_id == IDX_W'(N_REQ - 1)) ? '0 : grant_id + 1'b1;

`ifdef TIMER_DELAY_SCHED_ABORT_EN
    logic aborted;
    logic abort_hit;

    assign abort_hit = abort[grant_id] &&
                       (state inside {ST_WR_PL, ST_WR_PH, ST_WR_CTRL, ST_WAIT_IRQ});
`endif

    // Bus outputs are registered, so each state's write is set up on the edge entering it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= ST_IDLE;
            rr_ptr         <= '0;
            grant_id       <= '0;
            owner_oh       <= '0;
            delay_hi       <= '0;
            done           <= '0;
            sched_active   <= 1'b0;
            tmr_address    <= TMR_ADDR_STATUS;
            tmr_chipselect <= 1'b0;
            tmr_write_n    <= 1'b1;
            tmr_writedata  <= '0;
`ifdef TIMER_DELAY_SCHED_ABORT_EN
            aborted        <= 1'b0;
`endif
        end else begin
            done           <= '0;
            tmr_chipselect <= 1'b0;
            tmr_write_n    <= 1'b1;
`ifdef TIMER_DELAY_SCHED_ABORT_EN
            if (abort_hit) begin
                state          <= ST_ABORT;
                aborted        <= 1'b1;
                tmr_chipselect <= 1'b1;
                tmr_write_n    <= 1'b0;
                tmr_address    <= TMR_ADDR_CONTROL;
                tmr_writedata  <= CTRL_STOP;
            end else
`endif
            begin
                case (state)
                    ST_IDLE: begin
                        if (arb_any) begin
                            grant_id       <= arb_idx;
                            owner_oh       <= arb_grant;
                            delay_hi       <= clamped_delay[31:16];
                            sched_active   <= 1'b1;
                            tmr_chipselect <= 1'b1;
                            tmr_write_n    <= 1'b0;
                            tmr_address    <= TMR_ADDR_PERIODL;
                            tmr_writedata  <= clamped_delay[15:0];
                            state          <= ST_WR_PL;
                        end
                    end
                    ST_WR_PL: begin
                        tmr_chipselect <= 1'b1;
                        tmr_write_n    <= 1'b0;
                        tmr_address    <= TMR_ADDR_PERIODH;
                        tmr_writedata  <= delay_hi;
                        state          <= ST_WR_PH;
                    end
                    ST_WR_PH: begin
                        tmr_chipselect <= 1'b1;
                        tmr_write_n    <= 1'b0;
                        tmr_address    <= TMR_ADDR_CONTROL;
                        tmr_writedata  <= CTRL_ONESHOT_START;
                        state          <= ST_WR_CTRL;
                    end
                    ST_WR_CTRL: begin
                        state <= ST_WAIT_IRQ;
                    end
                    ST_WAIT_IRQ: begin
                        if (tmr_irq) begin
                            tmr_chipselect <= 1'b1;
                            tmr_write_n    <= 1'b0;
                            tmr_address    <= TMR_ADDR_STATUS;
                            tmr_writedata  <= STATUS_CLEAR;
                            state          <= ST_WR_STAT;
                        end
                    end
                    ST_WR_STAT: begin
`ifdef TIMER_DELAY_SCHED_ABORT_EN
                        if (aborted) begin
                            aborted      <= 1'b0;
                            sched_active <= 1'b0;
                            rr_ptr       <= next_ptr;
                            state        <= ST_IDLE;
                        end else
`endif
                        begin
                            done  <= owner_oh;
                            state <= ST_DONE;
                        end
                    end
                    ST_DONE: begin
                        sched_active <= 1'b0;
                        rr_ptr       <= next_ptr;
                        state        <= ST_IDLE;
                    end
`ifdef TIMER_DELAY_SCHED_ABORT_EN
                    ST_ABORT: begin
                        tmr_chipselect <= 1'b1;
                        tmr_write_n    <= 1'b0;
                        tmr_address    <= TMR_ADDR_STATUS;
                        tmr_writedata  <= STATUS_CLEAR;
                        state          <= ST_WR_STAT;
                    end
`endif
                    default: begin
                        sched_active <= 1'b0;
                        state        <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_timer_delay_sched.sv
// Directed bench for timer_delay_sched with a behavioural interval-timer model.
// Abort scenarios run only when TIMER_DELAY_SCHED_ABORT_EN is defined.
module tb_timer_delay_sched;

    localparam int N_REQ = 4;
    localparam int IDX_W = 2;

    logic                clk = 1'b0;
    logic                reset_n;
    logic [N_REQ-1:0]    req;
    logic [32*N_REQ-1:0] delay;
    logic [N_REQ-1:0]    abort;
    logic [N_REQ-1:0]    done;
    logic                sched_active;
    logic [IDX_W-1:0]    grant_id;
    logic [2:0]          tmr_address;
    logic                tmr_chipselect;
    logic                tmr_write_n;
    logic [15:0]         tmr_writedata;
    logic                tmr_irq;
    logic                model_irq;
    logic                force_irq;

    int checkCount = 0;
    int passCount  = 0;
    int cyc        = 0;

    typedef struct {
        logic [2:0]  addr;
        logic [15:0] data;
        int          c;
    } wr_t;
    wr_t wlog[$];

    timer_delay_sched #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .req            (req),
        .delay          (delay),
`ifdef TIMER_DELAY_SCHED_ABORT_EN
        .abort          (abort),
`endif
        .done           (done),
        .sched_active   (sched_active),
        .grant_id       (grant_id),
        .tmr_address    (tmr_address),
        .tmr_chipselect (tmr_chipselect),
        .tmr_write_n    (tmr_write_n),
        .tmr_writedata  (tmr_writedata),
        .tmr_irq        (tmr_irq)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    assign tmr_irq = model_irq | force_irq;

    always @(negedge clk) begin
        if (reset_n && tmr_chipselect && !tmr_write_n)
            wlog.push_back('{addr: tmr_address, data: tmr_writedata, c: cyc});
    end

    // Timer model: loads on the period-high write, irq delay+1 cycles later.
    logic [31:0] tm_cnt;
    logic [15:0] tm_pl;
    logic        tm_run;
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            model_irq <= 1'b0;
            tm_cnt    <= '0;
            tm_pl     <= '0;
            tm_run    <= 1'b0;
        end else begin
            if (tm_run) begin
                if (tm_cnt == 0) begin
                    model_irq <= 1'b1;
                    tm_run    <= 1'b0;
                end else begin
                    tm_cnt <= tm_cnt - 1;
                end
            end
            if (tmr_chipselect && !tmr_write_n) begin
                case (tmr_address)
                    3'd0: model_irq <= 1'b0;
                    3'd1: if (tmr_writedata[3]) tm_run <= 1'b0;
                    3'd2: tm_pl <= tmr_writedata;
                    3'd3: begin
                        tm_cnt <= {tmr_writedata, tm_pl};
                        tm_run <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCount++;
        if (got === exp) passCount++;
        else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic checkWrite(input string tag, input int idx, input logic [2:0] a, input logic [15:0] d);
        logic [31:0] got;
        got = (idx < wlog.size()) ? {13'd0, wlog[idx].addr, wlog[idx].data} : 32'hFFFF_FFFF;
        checkOutput(tag, got, {13'd0, a, d});
    endtask

    function automatic int wrCyc(input int idx);
        return (idx < wlog.size()) ? wlog[idx].c : -1000;
    endfunction

    function automatic logic [127:0] packDelays(input logic [31:0] d0, d1, d2, d3);
        return {d3, d2, d1, d0};
    endfunction

    task automatic applyStimulus(input logic [N_REQ-1:0] r, input logic [127:0] d);
        req   = r;
        delay = d;
    endtask

    task automatic doReset();
        reset_n   = 1'b0;
        req       = '0;
        abort     = '0;
        force_irq = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        wlog.delete();
    endtask

    task automatic waitDone(input int maxCyc, output logic [N_REQ-1:0] dv, output int dc);
        dv = '0;
        dc = -1;
        for (int i = 0; i < maxCyc; i++) begin
            @(negedge clk);
            if (done != '0) begin
                dv = done;
                dc = cyc;
                break;
            end
        end
        if (dc < 0) checkOutput("done timeout", 32'd0, 32'd1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [N_REQ-1:0] dv;
        int               dc;
        int               startCyc;
        logic [N_REQ-1:0] doneSeen;

        reset_n   = 1'b0;
        req       = '0;
        delay     = '0;
        abort     = '0;
        force_irq = 1'b0;

        @(negedge clk);
        checkOutput("rst done",      32'(done),           32'd0);
        checkOutput("rst active",    32'(sched_active),   32'd0);
        checkOutput("rst grant_id",  32'(grant_id),       32'd0);
        checkOutput("rst cs",        32'(tmr_chipselect), 32'd0);
        checkOutput("rst write_n",   32'(tmr_write_n),    32'd1);
        checkOutput("rst address",   32'(tmr_address),    32'd0);
        checkOutput("rst writedata", 32'(tmr_writedata),  32'd0);
        reset_n = 1'b1;
        @(negedge clk);
        wlog.delete();

        $display("[TB] single request, delay 10");
        applyStimulus(4'b0001, packDelays(32'd10, 32'd0, 32'd0, 32'd0));
        startCyc = cyc;
        waitDone(100, dv, dc);
        req = '0;
        checkOutput("t1 done vector", 32'(dv), 32'h1);
        checkOutput("t1 active at done", 32'(sched_active), 32'd1);
        checkWrite("t1 wr periodl", 0, 3'd2, 16'h000A);
        checkWrite("t1 wr periodh", 1, 3'd3, 16'h0000);
        checkWrite("t1 wr control", 2, 3'd1, 16'h0005);
        checkWrite("t1 wr status",  3, 3'd0, 16'h0000);
        checkOutput("t1 grant latency", 32'(wrCyc(0) - startCyc), 32'd1);
        checkOutput("t1 ph to done", 32'(dc - wrCyc(1)), 32'd14);
        checkOutput("t1 status before done", 32'(dc - wrCyc(3)), 32'd1);
        @(negedge clk);
        checkOutput("t1 active after", 32'(sched_active), 32'd0);
        checkOutput("t1 write count", 32'(wlog.size()), 32'd4);

        $display("[TB] all four requesting, round-robin");
        doReset();
        applyStimulus(4'b1111, packDelays(32'd3, 32'd3, 32'd3, 32'd3));
        for (int k = 0; k < 4; k++) begin
            waitDone(60, dv, dc);
            checkOutput($sformatf("t2 done order %0d", k), 32'(dv), 32'(4'b0001 << k));
            checkOutput($sformatf("t2 grant_id %0d", k), 32'(grant_id), 32'(k));
            req = req & ~dv;
        end
        repeat (3) @(negedge clk);
        checkOutput("t2 idle after", 32'(sched_active), 32'd0);

        $display("[TB] lone request 1, req dropped and delay changed mid-sequence");
        wlog.delete();
        applyStimulus(4'b0010, packDelays(32'd3, 32'd7, 32'd3, 32'd3));
        repeat (2) @(negedge clk);
        applyStimulus(4'b0000, packDelays(32'd3, 32'h0000_1234, 32'd3, 32'd3));
        waitDone(60, dv, dc);
        checkOutput("t3 done vector", 32'(dv), 32'h2);
        checkWrite("t3 wr periodl", 0, 3'd2, 16'h0007);
        checkWrite("t3 wr periodh", 1, 3'd3, 16'h0000);
        checkOutput("t3 ph to done", 32'(dc - wrCyc(1)), 32'd11);

        $display("[TB] large delay, reset during WAIT_IRQ");
        doReset();
        applyStimulus(4'b0100, packDelays(32'd0, 32'd0, 32'h0001_86A0, 32'd0));
        repeat (6) @(negedge clk);
        checkWrite("t4 wr periodl", 0, 3'd2, 16'h86A0);
        checkWrite("t4 wr periodh", 1, 3'd3, 16'h0001);
        checkWrite("t4 wr control", 2, 3'd1, 16'h0005);
        checkOutput("t4 waiting active", 32'(sched_active), 32'd1);
        checkOutput("t4 waiting grant", 32'(grant_id), 32'd2);
        checkOutput("t4 waiting cs", 32'(tmr_chipselect), 32'd0);
        #2 reset_n = 1'b0;
        req = '0;
        @(negedge clk);
        checkOutput("t4 rst done",      32'(done),           32'd0);
        checkOutput("t4 rst active",    32'(sched_active),   32'd0);
        checkOutput("t4 rst grant_id",  32'(grant_id),       32'd0);
        checkOutput("t4 rst cs",        32'(tmr_chipselect), 32'd0);
        checkOutput("t4 rst write_n",   32'(tmr_write_n),    32'd1);
        checkOutput("t4 rst address",   32'(tmr_address),    32'd0);
        checkOutput("t4 rst writedata", 32'(tmr_writedata),  32'd0);
        reset_n = 1'b1;
        wlog.delete();
        force_irq = 1'b1;
        doneSeen  = '0;
        repeat (4) begin
            @(negedge clk);
            doneSeen = doneSeen | done;
        end
        force_irq = 1'b0;
        checkOutput("t4 irq in idle writes", 32'(wlog.size()), 32'd0);
        checkOutput("t4 irq in idle done", 32'(doneSeen), 32'd0);
        checkOutput("t4 irq in idle active", 32'(sched_active), 32'd0);

        $display("[TB] zero delay clamps to one");
        doReset();
        applyStimulus(4'b1000, packDelays(32'd0, 32'd0, 32'd0, 32'd0));
        waitDone(60, dv, dc);
        req = '0;
        checkOutput("t5 done vector", 32'(dv), 32'h8);
        checkWrite("t5 wr periodl", 0, 3'd2, 16'h0001);
        checkWrite("t5 wr periodh", 1, 3'd3, 16'h0000);
        checkOutput("t5 ph to done", 32'(dc - wrCyc(1)), 32'd5);

`ifdef TIMER_DELAY_SCHED_ABORT_EN
        $display("[TB] abort of granted requester 2 in WAIT_IRQ");
        doReset();
        applyStimulus(4'b0100, packDelays(32'd0, 32'd2, 32'd20, 32'd0));
        repeat (5) @(negedge clk);
        abort = 4'b0001;
        @(negedge clk);
        abort    = 4'b0100;
        startCyc = cyc;
        doneSeen = '0;
        @(negedge clk);
        abort = '0;
        req   = '0;
        repeat (6) begin
            @(negedge clk);
            doneSeen = doneSeen | done;
        end
        checkWrite("t6 wr stop", 3, 3'd1, 16'h0008);
        checkWrite("t6 wr status", 4, 3'd0, 16'h0000);
        checkOutput("t6 stop timing", 32'(wrCyc(3) - startCyc), 32'd1);
        checkOutput("t6 no done", 32'(doneSeen), 32'd0);
        checkOutput("t6 active after", 32'(sched_active), 32'd0);
        checkOutput("t6 write count", 32'(wlog.size()), 32'd5);
        applyStimulus(4'b0110, packDelays(32'd0, 32'd2, 32'd2, 32'd0));
        waitDone(60, dv, dc);
        req = '0;
        checkOutput("t6 rr advanced", 32'(dv), 32'h2);
`endif

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/timer_delay_sched.md
Name: timer_delay_sched

Overview:
- Hardware scheduler that shares the single interval timer peripheral (16-bit memory-mapped slave, irq output) among N_REQ requesters needing one-shot delays.
- Grants one requester at a time (round-robin) and programs the timer's period and control registers directly over the timer slave port.
- Waits for timer irq, clears timer status, then pulses done to the owner.
- Sits beside the CPU master on the timer slave; the system mux selects this block's port while sched_active=1.

Parameters:
N_REQ, 4, number of requesters (2..8)
IDX_W, 2, width of grant index, = clog2(N_REQ)

Ports:
clk  in  1  clock
reset_n  in  1  reset, asynchronous, active-low
req  in  N_REQ  level request per requester; held until done
delay  in  32*N_REQ  per-requester delay in clk cycles, slice i = bits [32i+31:32i]
done  out  N_REQ  one-cycle pulse to granted requester on timeout
sched_active  out  1  block owns timer slave port
grant_id  out  IDX_W  index of current owner (valid while sched_active)
tmr_address  out  3  timer register address
tmr_chipselect  out  1  timer chipselect
tmr_write_n  out  1  timer write strobe, active-low
tmr_writedata  out  16  timer write data
tmr_irq  in  1  timer interrupt

Behaviour:
- Timer register map (word addresses):
  - 0 = status; any write clears timeout.
  - 1 = control; bit0 ITO, bit1 CONT, bit2 START, bit3 STOP.
  - 2 = period low; 3 = period high.
- Timer slave has no waitrequest: each write completes in one cycle.
- Reset values: done=0, sched_active=0, grant_id=0, tmr_chipselect=0, tmr_write_n=1, tmr_address=0, tmr_writedata=0, rr pointer=0, state IDLE.
- All tmr_* outputs are registered.
- FSM states: IDLE, WR_PL, WR_PH, WR_CTRL, WAIT_IRQ, WR_STAT, DONE.
  - IDLE:
    - If any req, pick the first set bit at or after rr pointer, wrapping.
    - Latch grant_id and delay, clamping delay 0 to 1.
    - Set sched_active=1 and go to WR_PL.
  - WR_PL: write addr 2, data = delay[15:0] -> WR_PH.
  - WR_PH: write addr 3, data = delay[31:16] -> WR_CTRL.
  - WR_CTRL: write addr 1, data 0x0005 (ITO=1, START=1, CONT=0) -> WAIT_IRQ.
  - WAIT_IRQ: chipselect=0; stay until tmr_irq=1 -> WR_STAT.
  - WR_STAT: write addr 0, data 0x0000 -> DONE.
  - DONE:
    - done[grant_id] pulses 1 cycle.
    - rr pointer = grant_id+1 mod N_REQ; sched_active=0 -> IDLE.
- Latency and timing:
  - Grant: 1 cycle after req seen in IDLE.
  - Timer expires delay+1 cycles after the WR_PH write (reload, then count down to 0).
  - done pulses 2 cycles after irq is sampled.
- Outside write states: tmr_chipselect=0, tmr_write_n=1.
- Boundary conditions:
  - req deasserted mid-sequence: ignored; sequence completes and done still pulses.
  - Requester must not reassert req in the cycle done pulses.
  - Simultaneous requests: round-robin; no requester starves beyond N_REQ-1 grants.
  - Delay value sampled only at grant; later changes ignored.
  - tmr_irq is ignored outside WAIT_IRQ.
  - Reset mid-operation: FSM returns to IDLE immediately. The timer is reset by the same reset_n.

Optional Feature:
TIMER_DELAY_SCHED_ABORT_EN
- With the macro: adds input abort [N_REQ].
  - abort[grant_id]=1 during WR_PL..WAIT_IRQ jumps to state ABORT.
  - ABORT: write addr 1, data 0x0008 (STOP) -> WR_STAT -> IDLE.
  - No done pulse; rr pointer advances.
  - abort in IDLE or DONE is ignored; abort for non-granted requesters is ignored.
- Without the macro: no abort port and no ABORT state.

Decomposition:
- Shared package timer_sched_pkg:
  - State enum.
  - Register address constants TMR_ADDR_STATUS/CONTROL/PERIODL/PERIODH.
  - Control bit constants and CTRL_ONESHOT_START=16'h0005, CTRL_STOP=16'h0008.
- One sub-module: rr_arbiter (N_REQ-bit request, pointer -> one-hot grant plus index), combinational with registered pointer in parent.

Test Plan:
- Single req[0], delay=10 -> writes (2,0x000A),(3,0x0000),(1,0x0005); with a timer model, done[0] pulses 11 cycles after the WR_PH write + 2; then write (0,0x0000).
- req=4'b1111 all delay=3 -> grants in order 0,1,2,3, each done exactly once; then req[1] only -> grant 1.
- delay=0x0001_86A0 -> period writes 0x86A0 then 0x0001; irq after 100001 cycles.
- delay=0 -> period_l write 0x0001, completes normally.
- reset_n low while in WAIT_IRQ -> next cycle all outputs at reset values, state IDLE, no done.
- ABORT_EN: abort[2] asserted in WAIT_IRQ while granted 2 -> write (1,0x0008), then (0,0x0000), no done[2], sched_active=0.
